bram_read_streamer: RTL and testbench
=====================================

# bram_read_streamer

Read-side sequencer for the on-chip feature/weight BRAM. On a start command it walks a strided region of word addresses, drives the BRAM byte-granular read address, absorbs the BRAM's one-cycle read latency, and delivers words on a valid/ready stream with full backpressure support. It sits directly downstream of the general-purpose BRAM and feeds the compute datapath (PE array / MAC line buffers).

## Interface
- DATA_WIDTH, 32, width of one BRAM word and of the output stream
- DEPTH, 8192, number of BRAM words
- OFF_SET_SHIFT, 2, byte-to-word shift applied by the BRAM on its read address
- ADDR_W, $clog2(DEPTH*2**OFF_SET_SHIFT), derived: byte read-address width (not overridden)
- CNT_W, $clog2(DEPTH)+1, derived: transfer-length width

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle command strobe, accepted only in IDLE
- base_addr  in  ADDR_W  byte address of first word, sampled with start
- stride  in  ADDR_W  byte increment between words, sampled with start
- count  in  CNT_W  number of words to stream, sampled with start
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at transfer completion
- rd_addr  out  ADDR_W  byte read address to BRAM (registered)
- bram_data  in  DATA_WIDTH  BRAM read data, valid one cycle after rd_addr is sampled
- m_valid  out  1  output word valid
- m_ready  in  1  consumer ready
- m_data  out  DATA_WIDTH  output word
- m_last  out  1  marks final word of the transfer

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: start=1 latches base_addr/stride/count; count=0 → done pulses next cycle, stay IDLE, no beats; else → RUN.
- RUN: each cycle a read is issued iff (fifo_count + in_flight) < 4; issue = rd_addr presents current address, address += stride (modulo 2^ADDR_W, wrap silently), issued counter +1. After the count-th issue → DRAIN.
- DRAIN: no issues; wait until all in-flight reads have landed and the FIFO has emptied via the final handshake, then done pulses, → IDLE.
- Latency pipe: a 2-stage valid shift register tracks in-flight reads; bram_data is written into the FIFO in the cycle after its address was presented.
- Output FIFO: 4 entries, each holds data and a last flag (set on the count-th word). m_valid = FIFO not empty; pop on m_valid & m_ready.
- start while busy=1 is ignored; stride=0 legal (repeats one word).
- rd_addr holds its last value when no read is issued.
- Reset mid-transfer: all state cleared immediately, in-flight reads and FIFO contents discarded, no done pulse.

## Timing
- Reset values: busy=0, done=0, rd_addr=0, m_valid=0, m_data=0, m_last=0, FSM=IDLE.
- start high in cycle N → busy high from N+1; rd_addr=base_addr in N+1; word captured at end of N+2; m_valid high in N+3.
- With m_ready held 1: one beat per cycle sustained; count words occupy cycles N+3 … N+2+count.
- done pulses in the cycle after the m_last handshake; busy falls in that same cycle.
- m_ready low: issue stops once fifo_count+in_flight reaches 4; no word is ever dropped or duplicated; m_data/m_last stable while m_valid & !m_ready.
- count=0: done at N+1, busy never asserts.

## Structure
- Shared package: FSM state enum (IDLE/RUN/DRAIN), FIFO depth constant (4), in-flight latency constant (BRAM read latency = 1, pipe depth 2).
- One natural sub-module: sync_fifo_small (4-entry register FIFO carrying {last, data}, with count output).

## Test plan
- Reset then start base=0x10, stride=4, count=4 over BRAM preloaded word[i]=i, m_ready=1 → m_data 4,5,6,7 in N+3..N+6, m_last on 7, done at N+7.
- count=0 → done pulse at N+1, m_valid never high, busy stays 0.
- count=8, m_ready toggling 1/0 every cycle → exactly 8 words in order, never more than 4 reads outstanding+buffered, data stable while stalled.
- base=max_addr-3 (last word), stride=4, count=3 → addresses wrap to 0x0 and 0x4; words DEPTH-1, 0, 1.
- start re-asserted during RUN → ignored, original transfer completes unchanged.
- rst_n pulsed low mid-transfer (after 2 beats) → all outputs return to reset values asynchronously; new start afterwards streams correctly from its own base.

Source files
------------

// File: rtl/bram_read_streamer_pkg.sv
// Shared types and constants for the BRAM read streamer: FSM states, output
// buffer depth and the read-latency pipe depth.
package bram_read_streamer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int FIFO_DEPTH  = 4;
  localparam int FIFO_CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int BRAM_RD_LAT = 1;
  // Stage 0: address on rd_addr; stage 1: data on bram_data.
  localparam int PIPE_DEPTH  = BRAM_RD_LAT + 1;

endpackage

// File: rtl/bram_read_streamer_sync_fifo_small.sv
// Small register FIFO carrying {last, data}; allows write-while-full when a
// pop happens in the same cycle.
module sync_fifo_small
  import bram_read_streamer_pkg::*;
#(
  parameter int WIDTH = 33
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic [FIFO_CNT_W-1:0] count,
  output logic                  empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0]      mem_reg [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [FIFO_CNT_W-1:0] count_reg;
  logic                  do_wr;
  logic                  do_rd;

  assign do_rd = rd_en & (count_reg != '0);
  assign do_wr = wr_en & ((count_reg != FIFO_CNT_W'(FIFO_DEPTH)) | do_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_wr) begin
        mem_reg[wr_ptr_reg] <= wr_data;
        wr_ptr_reg          <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_rd) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count_reg <= count_reg + FIFO_CNT_W'(1);
        2'b01:   count_reg <= count_reg - FIFO_CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rd_data = mem_reg[rd_ptr_reg];
  assign count   = count_reg;
  assign empty   = (count_reg == '0);

endmodule

// File: rtl/bram_read_streamer.sv
// Strided BRAM read sequencer: issues byte addresses, absorbs the one-cycle
// read latency and streams words out on valid/ready with backpressure.
module bram_read_streamer
  import bram_read_streamer_pkg::*;
#(
  parameter  int DATA_WIDTH    = 32,
  parameter  int DEPTH         = 8192,
  parameter  int OFF_SET_SHIFT = 2,
  localparam int ADDR_W        = $clog2(DEPTH * 2**OFF_SET_SHIFT),
  localparam int CNT_W         = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W-1:0]     stride,
  input  logic [CNT_W-1:0]      count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [DATA_WIDTH-1:0] bram_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam int OCC_W = FIFO_CNT_W + 1;

  state_t                state_reg, state_next;
  logic [ADDR_W-1:0]     addr_reg, stride_reg, rd_addr_reg;
  logic [ADDR_W-1:0]     cur_addr, cur_stride;
  logic [CNT_W-1:0]      count_reg, issued_reg, issued_next;
  logic [PIPE_DEPTH-1:0] pipe_vld_reg, pipe_last_reg;
  logic                  done_reg, done_next;
  logic                  issue, issue_last, load;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic                  fifo_empty;
  logic [DATA_WIDTH:0]   fifo_rd;
  logic [OCC_W-1:0]      occupancy;
  logic                  pop;
  logic                  head_last;

  assign head_last = fifo_rd[DATA_WIDTH];
  assign pop       = ~fifo_empty & m_ready;

  // Words buffered plus reads still travelling through the latency pipe.
  always_comb begin
    occupancy = OCC_W'(fifo_count);
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      occupancy = occupancy + OCC_W'(pipe_vld_reg[i]);
    end
  end

  // The first read is issued on the start edge so rd_addr shows base_addr
  // in the very first busy cycle.
  always_comb begin
    state_next  = state_reg;
    done_next   = 1'b0;
    load        = 1'b0;
    issue       = 1'b0;
    cur_addr    = addr_reg;
    cur_stride  = stride_reg;
    issued_next = issued_reg + CNT_W'(1);
    issue_last  = (issued_next == count_reg);
    case (state_reg)
      IDLE: begin
        cur_addr    = base_addr;
        cur_stride  = stride;
        issued_next = CNT_W'(1);
        issue_last  = (count == CNT_W'(1));
        if (start) begin
          load = 1'b1;
          if (count == '0) begin
            done_next = 1'b1;
          end else begin
            issue      = 1'b1;
            state_next = issue_last ? DRAIN : RUN;
          end
        end
      end
      RUN: begin
        if (occupancy < OCC_W'(FIFO_DEPTH)) begin
          issue = 1'b1;
          if (issue_last) state_next = DRAIN;
        end
      end
      DRAIN: begin
        // Popping the tagged last word means nothing is left in flight.
        if (pop && head_last) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg      <= '0;
      stride_reg    <= '0;
      rd_addr_reg   <= '0;
      count_reg     <= '0;
      issued_reg    <= '0;
      pipe_vld_reg  <= '0;
      pipe_last_reg <= '0;
      done_reg      <= 1'b0;
    end else begin
      done_reg      <= done_next;
      pipe_vld_reg  <= {pipe_vld_reg[PIPE_DEPTH-2:0], issue};
      pipe_last_reg <= {pipe_last_reg[PIPE_DEPTH-2:0], issue & issue_last};
      if (load) begin
        stride_reg <= stride;
        count_reg  <= count;
      end
      if (issue) begin
        rd_addr_reg <= cur_addr;
        addr_reg    <= cur_addr + cur_stride;
        issued_reg  <= issued_next;
      end
    end
  end

  sync_fifo_small #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (pipe_vld_reg[PIPE_DEPTH-1]),
    .wr_data ({pipe_last_reg[PIPE_DEPTH-1], bram_data}),
    .rd_en   (m_ready),
    .rd_data (fifo_rd),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

  assign busy    = (state_reg != IDLE);
  assign done    = done_reg;
  assign rd_addr = rd_addr_reg;
  assign m_valid = ~fifo_empty;
  assign m_data  = fifo_rd[DATA_WIDTH-1:0];
  assign m_last  = head_last;

endmodule

// File: tb/tb_bram_read_streamer.sv
// Directed bench for bram_read_streamer with a behavioural BRAM and an
// expected-word scoreboard checked at every output handshake.
module tb_bram_read_streamer;

  localparam int DW     = 32;
  localparam int DEPTH  = 8192;
  localparam int ADDR_W = 15;
  localparam int CNT_W  = 14;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] stride = '0;
  logic [CNT_W-1:0]  count = '0;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rd_addr;
  logic [DW-1:0]     bram_data = '0;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [DW-1:0]     m_data;
  logic              m_last;

  logic [DW-1:0] bram [DEPTH];
  exp_t          exp_q [$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int beats, done_cnt, done_cyc, first_beat, last_beat, issued_cnt, start_cyc;
  int ready_mode = 0;  // 0: ready high, 1: toggle, 2: ready low
  bit valid_seen, busy_seen, chk_occ, prev_stall, busy_at_done;
  logic [DW-1:0]     prev_data;
  logic              prev_last;
  logic [ADDR_W-1:0] prev_rd_addr;

  bram_read_streamer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .stride    (stride),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .rd_addr   (rd_addr),
    .bram_data (bram_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bram_data <= bram[rd_addr[ADDR_W-1:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_done"}, done, 0);
    chk({p, "_rd_addr"}, rd_addr, 0);
    chk({p, "_m_valid"}, m_valid, 0);
    chk({p, "_m_data"}, m_data, 0);
    chk({p, "_m_last"}, m_last, 0);
  endtask

  // Observe the current cycle, score any handshake, then advance one clock.
  task automatic step();
    exp_t e;
    case (ready_mode)
      1:       m_ready = (cyc % 2 == 0);
      2:       m_ready = 1'b0;
      default: m_ready = 1'b1;
    endcase
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = busy;
    end
    if (m_valid) valid_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
    if (rd_addr !== prev_rd_addr) begin
      issued_cnt++;
      prev_rd_addr = rd_addr;
    end
    if (chk_occ) chk("outstanding_le4", (issued_cnt - beats) <= 4, 1);
    if (prev_stall) begin
      chk("stall_data", m_data, prev_data);
      chk("stall_last", m_last, prev_last);
    end
    if (m_valid && m_ready) begin
      chk("beat_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        $display("beat %0d cyc=%0d data=%0h last=%0b", beats, cyc, m_data, m_last);
        chk("beat_data", m_data, e.data);
        chk("beat_last", m_last, e.last);
      end
      if (first_beat < 0) first_beat = cyc;
      last_beat = cyc;
      beats++;
    end
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic launch(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] s,
                        input logic [CNT_W-1:0] n);
    logic [ADDR_W-1:0] a;
    exp_t e;
    a = b;
    for (int i = 0; i < int'(n); i++) begin
      e.data = bram[a[ADDR_W-1:2]];
      e.last = (i == int'(n) - 1);
      exp_q.push_back(e);
      a = a + s;
    end
    beats = 0; first_beat = -1; last_beat = -1; issued_cnt = 0;
    valid_seen = 1'b0; busy_seen = 1'b0; prev_stall = 1'b0;
    prev_rd_addr = rd_addr;
    start_cyc = cyc;
    $display("start base=%0h stride=%0h count=%0d cyc=%0d", b, s, n, cyc);
    base_addr = b; stride = s; count = n; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0, n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      step();
      n++;
    end
    chk("done_within_budget", done_cnt - d0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, n;
    done_cnt = 0; beats = 0; first_beat = -1; last_beat = -1; issued_cnt = 0;
    chk_occ = 1'b0; prev_stall = 1'b0; prev_rd_addr = '0;
    for (int i = 0; i < DEPTH; i++) bram[i] = i;

    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst_n = 1'b1;
    step();

    // Basic stream with fixed latency and done timing.
    ready_mode = 0;
    launch(15'h10, 15'd4, 14'd4);
    chk("t1_busy_n1", busy, 1);
    chk("t1_rd_addr_n1", rd_addr, 'h10);
    wait_done(50);
    chk("t1_first_beat", first_beat - start_cyc, 3);
    chk("t1_last_beat", last_beat - start_cyc, 6);
    chk("t1_done_cyc", done_cyc - start_cyc, 7);
    chk("t1_busy_at_done", busy_at_done, 0);
    chk("t1_beats", beats, 4);
    chk("t1_q_empty", exp_q.size(), 0);

    // Zero-length transfer.
    launch(15'h40, 15'd4, 14'd0);
    chk("t2_done_n1", done, 1);
    chk("t2_busy_n1", busy, 0);
    d0 = done_cnt;
    repeat (6) step();
    chk("t2_done_once", done_cnt - d0, 1);
    chk("t2_no_valid", valid_seen, 0);
    chk("t2_no_busy", busy_seen, 0);

    // Backpressure with ready toggling every cycle.
    ready_mode = 1;
    chk_occ = 1'b1;
    launch(15'h100, 15'd4, 14'd8);
    wait_done(100);
    chk_occ = 1'b0;
    chk("t3_beats", beats, 8);
    chk("t3_q_empty", exp_q.size(), 0);

    // Address wrap past the top of the byte space.
    ready_mode = 0;
    launch(15'h7FFC, 15'd4, 14'd3);
    chk("t4_rd_addr_n1", rd_addr, 'h7FFC);
    wait_done(50);
    chk("t4_beats", beats, 3);
    chk("t4_q_empty", exp_q.size(), 0);

    // Start while busy must be ignored.
    ready_mode = 2;
    launch(15'h200, 15'd8, 14'd6);
    repeat (3) step();
    base_addr = 15'h500; stride = 15'd4; count = 14'd2; start = 1'b1;
    step();
    start = 1'b0;
    chk("t5_busy", busy, 1);
    ready_mode = 0;
    wait_done(50);
    d0 = done_cnt;
    repeat (8) step();
    chk("t5_no_extra_done", done_cnt - d0, 0);
    chk("t5_beats", beats, 6);
    chk("t5_q_empty", exp_q.size(), 0);

    // Asynchronous reset in the middle of a transfer.
    launch(15'h300, 15'd4, 14'd8);
    n = 0;
    while (beats < 2 && n < 20) begin
      step();
      n++;
    end
    chk("t6_two_beats", beats, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("t6_async");
    exp_q.delete();
    d0 = done_cnt;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("t6_no_done", done_cnt - d0, 0);
    launch(15'h400, 15'd4, 14'd5);
    chk("t6_rd_addr_n1", rd_addr, 'h400);
    wait_done(50);
    chk("t6_beats", beats, 5);
    chk("t6_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
